// File: rtl/clk_nco_gen.sv
// Multi-channel numerically-controlled clock generator: per-channel phase accumulators
// with glitch-free tuning-word updates, phase realignment and a settle/lock indicator.
module clk_nco_gen #(
   parameter int unsigned     NUM_CLOCKS  = 4,
   parameter int unsigned     ACC_W       = 32,
   parameter longint unsigned DEFAULT_TW  = 422212466,
   parameter int unsigned     LOCK_CYCLES = 1024
) (
   input  logic                  refclk,
   input  logic                  rst_n,
   input  logic                  sync,
   input  logic                  wr_en,
   input  logic [2:0]            wr_sel,
   input  logic [ACC_W-1:0]      wr_data,
   output logic                  wr_ack,
   output logic [NUM_CLOCKS-1:0] outclk,
   output logic [NUM_CLOCKS-1:0] tick,
   output logic                  locked
);

   localparam logic [ACC_W-1:0] HALF     = {1'b1, {(ACC_W-1){1'b0}}};
   localparam longint unsigned  HALF_VAL = 64'd1 << (ACC_W-1);
   localparam logic [ACC_W-1:0] DEF_TW   = (DEFAULT_TW > HALF_VAL) ? HALF : ACC_W'(DEFAULT_TW);
   localparam int unsigned      CNT_W    = $clog2(LOCK_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCK_CYCLES);
   localparam logic [3:0]       NCLK     = 4'(NUM_CLOCKS);

   logic [ACC_W-1:0]      acc   [NUM_CLOCKS];
   logic [ACC_W-1:0]      tw    [NUM_CLOCKS];
   logic [ACC_W-1:0]      tw_sh [NUM_CLOCKS];
   logic [ACC_W:0]        sum   [NUM_CLOCKS];
   logic [NUM_CLOCKS-1:0] pend, pend_nxt, apply, hit;
   logic                  accept;
   logic [ACC_W-1:0]      wr_word;
   logic [CNT_W-1:0]      cnt, cnt_nxt;

   always_comb begin
      sum      = '{default: '0};
      apply    = '0;
      hit      = '0;
      pend_nxt = '0;
      accept   = wr_en && ({1'b0, wr_sel} < NCLK);
      wr_word  = (wr_data > HALF) ? HALF : wr_data;
      for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
         sum[i]   = {1'b0, acc[i]} + {1'b0, tw[i]};
         // Swap words only at a wrap, while stopped, or on realign, so no runt period appears.
         apply[i] = pend[i] && (sync || sum[i][ACC_W] || (tw[i] == '0));
         hit[i]   = accept && (wr_sel == 3'(i));
         // A write coinciding with an apply refills the shadow and stays pending.
         pend_nxt[i] = hit[i] || (pend[i] && !apply[i]);
      end
      if (accept)
         cnt_nxt = CNT_LOAD;
      else if (cnt != '0)
         cnt_nxt = cnt - CNT_W'(1);
      else
         cnt_nxt = cnt;
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
            acc[i]   <= '0;
            tw[i]    <= DEF_TW;
            tw_sh[i] <= DEF_TW;
         end
         pend   <= '0;
         outclk <= '0;
         tick   <= '0;
         wr_ack <= 1'b0;
         cnt    <= CNT_LOAD;
         locked <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
            if (sync) begin
               acc[i]    <= '0;
               outclk[i] <= 1'b0;
               tick[i]   <= 1'b0;
            end else begin
               acc[i]    <= sum[i][ACC_W-1:0];
               outclk[i] <= sum[i][ACC_W-1];
               tick[i]   <= sum[i][ACC_W];
            end
            if (apply[i])
               tw[i] <= tw_sh[i];
            if (hit[i])
               tw_sh[i] <= wr_word;
         end
         pend   <= pend_nxt;
         wr_ack <= accept;
         cnt    <= cnt_nxt;
         locked <= (cnt_nxt == '0) && (pend_nxt == '0);
      end
   end

endmodule

// File: tb/tb_clk_nco_gen.sv
// Bench for clk_nco_gen: directed scenarios plus random writes/syncs, every cycle
// compared against a phase-arithmetic reference model.
module tb_clk_nco_gen;

   localparam int unsigned     NC   = 4;
   localparam int              LOCK = 1024;
   localparam longint unsigned MOD  = 64'd1 << 32;
   localparam longint unsigned HALF = 64'd1 << 31;
   localparam longint unsigned DEFW = 64'd1 << 30;

   logic          refclk = 1'b0;
   logic          rst_n  = 1'b1;
   logic          sync   = 1'b0;
   logic          wr_en  = 1'b0;
   logic [2:0]    wr_sel = '0;
   logic [31:0]   wr_data = '0;
   logic          wr_ack, locked;
   logic [NC-1:0] outclk, tick;

   always #4 refclk = ~refclk;

   clk_nco_gen #(
      .NUM_CLOCKS (NC),
      .ACC_W      (32),
      .DEFAULT_TW (DEFW),
      .LOCK_CYCLES(LOCK)
   ) dut (
      .refclk (refclk),
      .rst_n  (rst_n),
      .sync   (sync),
      .wr_en  (wr_en),
      .wr_sel (wr_sel),
      .wr_data(wr_data),
      .wr_ack (wr_ack),
      .outclk (outclk),
      .tick   (tick),
      .locked (locked)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: phase as an integer modulo 2^32, lock as elapsed time since last write.
   longint unsigned m_phase [NC];
   longint unsigned m_word  [NC];
   longint unsigned m_next  [NC];
   bit              m_pend  [NC];
   logic [NC-1:0]   m_out, m_tick;
   logic            m_ack, m_lock;
   int              cyc, last_evt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int n = 0; n < NC; n++) begin
         m_phase[n] = 0;
         m_word[n]  = DEFW;
         m_next[n]  = DEFW;
         m_pend[n]  = 0;
      end
      m_out = '0; m_tick = '0; m_ack = 0; m_lock = 0;
      cyc = 0; last_evt = 0;
   endtask

   task automatic model_step();
      longint unsigned total_phase;
      bit wrapped, accepted, any_pend;
      cyc++;
      for (int n = 0; n < NC; n++) begin
         total_phase = m_phase[n] + m_word[n];
         wrapped = (total_phase >= MOD);
         if (sync) begin
            m_phase[n] = 0;
            m_out[n]   = 1'b0;
            m_tick[n]  = 1'b0;
         end else begin
            m_phase[n] = total_phase % MOD;
            m_out[n]   = (m_phase[n] >= HALF);
            m_tick[n]  = wrapped;
         end
         if (m_pend[n] && (sync || wrapped || m_word[n] == 0)) begin
            m_word[n] = m_next[n];
            m_pend[n] = 0;
         end
      end
      accepted = wr_en && (int'(wr_sel) < NC);
      if (accepted) begin
         m_next[wr_sel] = (longint'(wr_data) > HALF) ? HALF : longint'(wr_data);
         m_pend[wr_sel] = 1;
         last_evt = cyc;
      end
      m_ack = accepted;
      any_pend = 0;
      for (int n = 0; n < NC; n++) any_pend |= m_pend[n];
      m_lock = ((cyc - last_evt) >= LOCK) && !any_pend;
   endtask

   task automatic step();
      @(posedge refclk);
      model_step();
      #1;
      chk("outclk", outclk, m_out);
      chk("tick", tick, m_tick);
      chk("wr_ack", wr_ack, m_ack);
      chk("locked", locked, m_lock);
   endtask

   task automatic write(input int sel, input logic [31:0] data);
      wr_en = 1'b1; wr_sel = 3'(sel); wr_data = data;
      step();
      wr_en = 1'b0;
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'h4000_0000;
         3: return 32'h2000_0000;
         4: return 32'hFFFF_FFFF;
         default: return 32'($urandom_range(32'hFFFF_FFFF, 32'h0400_0000));
      endcase
   endfunction

   initial begin
      int first_lock, w, lock_at, n0, n1;
      int tq[$];
      logic exp_bit;

      model_reset();
      #1 rst_n = 1'b0;
      #2;
      chk("reset_outclk", outclk, 0);
      chk("reset_tick", tick, 0);
      chk("reset_ack", wr_ack, 0);
      chk("reset_locked", locked, 0);
      @(negedge refclk); @(negedge refclk);
      rst_n = 1'b1;

      // Defaults at 2^30: tick every 4 cycles, lock after exactly 1024 cycles.
      first_lock = 0;
      for (int i = 0; i < 1030; i++) begin
         step();
         if (cyc <= 16) chk("default_tick_period", tick, (cyc % 4 == 0) ? 4'hF : 4'h0);
         if (locked === 1'b1 && first_lock == 0) first_lock = cyc;
      end
      chk("lock_rise", first_lock, 1024);

      // Retune ch0 mid-period: phase is at 2^31 now, so the wrap comes on the next edge.
      write(0, 32'h2000_0000);
      w = cyc;
      chk("retune_ack", wr_ack, 1);
      chk("retune_lock_drop", locked, 0);
      for (int i = 0; i < 40; i++) begin
         step();
         if (tick[0] === 1'b1) tq.push_back(cyc);
      end
      chk("retune_tick_count", tq.size(), 5);
      if (tq.size() > 0) chk("retune_first_wrap", tq[0], w + 1);
      for (int k = 1; k < tq.size(); k++) chk("retune_gap", tq[k] - tq[k-1], 8);
      lock_at = 0;
      for (int i = 0; i < 1100 && lock_at == 0; i++) begin
         step();
         if (locked === 1'b1) lock_at = cyc;
      end
      chk("relock_delay", lock_at - w, 1024);

      // Stop ch1, then restart at Fclk/2.
      write(1, 32'h0);
      for (int i = 0; i < 8; i++) step();
      exp_bit = m_out[1];
      for (int i = 0; i < 10; i++) begin
         step();
         chk("stop_tick", tick[1], 0);
         chk("stop_hold", outclk[1], exp_bit);
      end
      write(1, 32'h8000_0000);
      step();
      exp_bit = m_out[1];
      for (int i = 0; i < 6; i++) begin
         step();
         exp_bit = ~exp_bit;
         chk("restart_toggle", outclk[1], exp_bit);
      end

      // Clamp on ch2, then an out-of-range select.
      write(2, 32'hFFFF_FFFF);
      for (int i = 0; i < 6; i++) step();
      exp_bit = m_out[2];
      for (int i = 0; i < 6; i++) begin
         step();
         exp_bit = ~exp_bit;
         chk("clamp_toggle", outclk[2], exp_bit);
      end
      write(5, 32'h1234_5678);
      chk("bad_sel_ack", wr_ack, 0);
      for (int i = 0; i < 4; i++) step();

      // Arbitrary phases, then realign.
      write(0, 32'($urandom_range(32'h7FFF_FFFF, 32'h1000_0000)));
      repeat ($urandom_range(3, 20)) step();
      write(0, 32'h4000_0000);
      write(1, 32'h2000_0000);
      repeat ($urandom_range(5, 15)) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      chk("sync_outclk", outclk[1:0], 0);
      chk("sync_tick", tick[1:0], 0);
      n0 = 0; n1 = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         if (tick[0] === 1'b1) n0++;
         if (tick[1] === 1'b1) begin
            n1++;
            chk("align_coincide", tick[0], 1);
            chk("align_every_second", n0 % 2, 0);
         end
      end
      chk("align_count", n1, 4);

      // Random writes and syncs.
      for (int i = 0; i < 400; i++) begin
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_sel  = 3'($urandom_range(0, 7));
         wr_data = rand_word();
         sync    = ($urandom_range(0, 31) == 0);
         step();
      end
      wr_en = 1'b0; sync = 1'b0;

      // Leave ch0 on a very slow word so the next write stays pending, then reset.
      write(0, 32'h10);
      for (int i = 0; i < 70; i++) step();
      write(0, 32'h8000_0000);
      step(); step();
      chk("pend_before_reset", m_pend[0], 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_outclk", outclk, 0);
      chk("async_tick", tick, 0);
      chk("async_ack", wr_ack, 0);
      chk("async_locked", locked, 0);
      model_reset();
      @(negedge refclk); @(negedge refclk);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         chk("post_reset_period", tick, (cyc % 4 == 0) ? 4'hF : 4'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clk_nco_gen.md
# clk_nco_gen

Parametrised multi-channel numerically-controlled clock generator running in the PLL output domain (125 MHz on the current board). It produces up to 8 independent square-wave clocks and matching one-cycle tick strobes, each with a runtime-programmable tuning word. Typical outputs are the audio MCLK, BCLK and LRCLK enables for the WAV playback path. Tuning-word changes are glitch-free, channels can be phase-aligned on demand, and a `locked` status output follows the PLL wrapper's semantics.

## Interface
- `NUM_CLOCKS`, 4: number of output channels, 1..8.
- `ACC_W`, 32: phase accumulator and tuning word width, 8..32.
- `DEFAULT_TW`, 422212466: tuning word loaded into every channel at reset. This gives 12.288 MHz at 125 MHz with `ACC_W`=32.
- `LOCK_CYCLES`, 1024: settle time, in clock cycles, before `locked` asserts. Must be at least 1.
- `refclk` input 1: sole clock, PLL output.
- `rst_n` input 1: asynchronous, active-low reset.
- `sync` input 1: single-cycle pulse that realigns all channel phases.
- `wr_en` input 1: tuning-word write strobe.
- `wr_sel` input 3: target channel index.
- `wr_data` input `ACC_W`: new tuning word.
- `wr_ack` output 1: one-cycle acknowledge of an accepted write.
- `outclk` output `NUM_CLOCKS`: square-wave outputs, registered.
- `tick` output `NUM_CLOCKS`: one-cycle pulse per output period, registered.
- `locked` output 1: all channels are stable.

## Operation
- Each channel n has three registers: accumulator `acc[n]` (`ACC_W` bits), active word `tw[n]`, and shadow word `tw_sh[n]` with a pending flag `pend[n]`.
- Every cycle, the channel computes `{carry, acc[n]} <= acc[n] + tw[n]`, an (`ACC_W`+1)-bit sum that wraps modulo 2^`ACC_W`.
- Output frequency is Fclk × `tw` / 2^`ACC_W`.
- `outclk[n]` is the registered MSB of the updated `acc[n]`.
- `tick[n]` is the registered carry, so it pulses exactly once per wrap.
- Write path:
  - The write is accepted when `wr_en`=1 and `wr_sel` < `NUM_CLOCKS`.
  - On acceptance, `tw_sh[sel]` takes the write value and `pend[sel]` is set. `wr_ack` pulses the following cycle.
  - If `wr_sel` ≥ `NUM_CLOCKS`, the write is ignored and there is no ack.
- Clamping: a `wr_data` value above 2^(`ACC_W`-1) is stored as 2^(`ACC_W`-1), so the maximum output is Fclk/2.
- A tuning word of 0 stops the channel. Its accumulator holds its value, so `outclk` holds and `tick` stays 0.
- Pending words are applied glitch-free. If `pend[n]` is set, `tw[n]` takes `tw_sh[n]` and `pend[n]` clears on whichever of these comes first:
  - the cycle the channel wraps (carry=1);
  - any cycle, if `tw[n]` is 0;
  - a `sync` cycle.
- Once applied, the new word governs the next accumulation.
- A write landing in the same cycle as an apply overwrites the shadow register and keeps `pend` set. The latest write always wins.
- `sync` clears every `acc[n]` to 0 and applies all pending words. In that same cycle `tick` is 0 and `outclk` is driven to 0.
- `locked` behaviour:
  - A down-counter loads `LOCK_CYCLES` on reset release and on every accepted write. It also counts any cycle in which some `pend` bit is set.
  - `locked`=1 only when the counter is 0 and no `pend` bit is set.
  - `locked` drops the cycle after an accepted write.
  - `sync` does not affect `locked`.

## Timing
- Reset values:
  - `acc` is 0.
  - `tw` and `tw_sh` are `DEFAULT_TW`, clamped.
  - `pend` is 0.
  - `outclk`, `tick`, `wr_ack` and `locked` are 0.
- Mid-operation reset clears all state immediately and discards pending words.
- The first accumulation happens on the first `refclk` edge with `rst_n` high.
- `locked` first asserts `LOCK_CYCLES` cycles after reset deassertion.
- Output latency: `outclk` and `tick` change 1 cycle after the accumulator edge that causes them.
- `wr_ack` asserts 1 cycle after `wr_en`.
- Apply latency: a new word takes effect no later than 2^`ACC_W`/`tw_old` cycles after the write, rounded up.
- Phase alignment: after `sync`, all channels whose tuning words are integer multiples of each other tick together on common boundaries.
- Tick spacing: for `tw` = 2^k, `tick` is exactly periodic with period 2^(`ACC_W`-k) cycles. For other words the spacing is ⌊2^`ACC_W`/tw⌋ or that value + 1 cycles.

## Test plan
- **Reset defaults:** set `ACC_W`=32, `DEFAULT_TW`=2^30, release reset.
  - `tick[*]` pulses every 4 cycles.
  - `outclk` is 2 cycles high, 2 cycles low.
  - `locked` rises exactly 1024 cycles after release.
- **Glitch-free retune:** on ch0 running 2^30, write `wr_data`=2^29 mid-period.
  - `wr_ack` pulses 1 cycle later and `locked` drops.
  - The period stays 4 until the next wrap, then becomes 8 with no runt pulse.
  - `locked` returns 1024 cycles after the write.
- **Stop and restart:** write 0 to ch1, then 2^31.
  - `outclk[1]` holds and `tick[1]` is 0.
  - The second write applies the next cycle and ch1 toggles every cycle.
- **Clamp and invalid select:** write `wr_data`=0xFFFFFFFF to ch2, then write with `wr_sel`=5 (`NUM_CLOCKS`=4).
  - ch2 runs at Fclk/2.
  - The `wr_sel`=5 write gives no `wr_ack`, and all channels and `locked` are unchanged.
- **Sync alignment:** ch0=2^30, ch1=2^29 with arbitrary phases, then pulse `sync`.
  - Both accumulators read 0.
  - Thereafter each `tick[1]` coincides with every second `tick[0]`.
- **Async reset mid-retune:** drop `rst_n` while `pend[0]`=1.
  - All outputs go to 0 without waiting for a clock.
  - After release, ch0 runs at `DEFAULT_TW`.
